// File: rtl/vmu_ls_seq.sv
// -----------------------------------------------------------------------------
// vmu_ls_seq -- issue stage for vector load/store instructions.
//
// Takes one vector memory instruction per valid/ready handshake. It splits the
// instruction into lane-group beats for the LSU address-generation stage. After
// the last beat it waits ISSUE_GAP idle cycles, so that the fixed-latency
// LSU/SPM pipeline empties before the next instruction issues.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   i_ins_vld/o_ins_rdy   instruction handshake (ready only while IDLE)
//   i_ins_op              load/store opcode, latched on accept
//   i_ins_scalar          base address operand, latched on accept
//   i_ins_vl              vector length in elements (clamped to VLMAX)
//   i_stall               downstream hold; suppresses beat issue
//   o_ls_vld              beat valid to the LSU
//   o_seq_vmu_cnt         beat index within the instruction
//   o_seq_vmu_op_ls       latched opcode
//   o_seq_vmu_scalar_ls   latched scalar
//   o_busy                sequencer not idle
//   o_done                one-cycle pulse when an instruction retires
//
// Optional feature macro VMU_LS_SEQ_PERF_EN adds two saturating counters:
//   o_perf_beats          number of issued beats
//   o_perf_stall          number of ISSUE cycles held by i_stall
// -----------------------------------------------------------------------------
module vmu_ls_seq #(
  parameter int LSU_OP_WIDTH = 2,
  parameter int SCALAR_WIDTH = 32,
  parameter int VLMAX        = 256,
  parameter int NUM_LANE     = 32,
  parameter int ISSUE_GAP    = 4,
  parameter int CNT_W        = $clog2(VLMAX / NUM_LANE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_ins_vld,
  output logic                     o_ins_rdy,
  input  logic [LSU_OP_WIDTH-1:0]  i_ins_op,
  input  logic [SCALAR_WIDTH-1:0]  i_ins_scalar,
  input  logic [$clog2(VLMAX):0]   i_ins_vl,
  input  logic                     i_stall,
  output logic                     o_ls_vld,
  output logic [CNT_W-1:0]         o_seq_vmu_cnt,
  output logic [LSU_OP_WIDTH-1:0]  o_seq_vmu_op_ls,
  output logic [SCALAR_WIDTH-1:0]  o_seq_vmu_scalar_ls,
  output logic                     o_busy,
  output logic                     o_done
`ifdef VMU_LS_SEQ_PERF_EN
  ,
  output logic [31:0]              o_perf_beats,
  output logic [31:0]              o_perf_stall
`endif
);

  localparam int VL_W    = $clog2(VLMAX) + 1;
  localparam int LANE_SH = $clog2(NUM_LANE);
  // The first DRAIN cycle holds ISSUE_GAP-1, so DRAIN lasts exactly ISSUE_GAP cycles.
  localparam logic [3:0] GAP_LOAD = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          last_q;     // index of the final beat (beats-1)
  logic [3:0]                gap_q;
  logic [LSU_OP_WIDTH-1:0]   op_q;
  logic [SCALAR_WIDTH-1:0]   scalar_q;
  logic                      done_q;
  logic                      done_set;
  logic                      accept;
  logic                      beat_last;
  logic [VL_W-1:0]           vl_clamp;
  logic [VL_W-1:0]           beats;
  logic [VL_W-1:0]           beats_m1;

  // VLMAX + NUM_LANE - 1 < 2*VLMAX. The round-up sum therefore fits in VL_W bits.
  assign vl_clamp  = (i_ins_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : i_ins_vl;
  assign beats     = (vl_clamp + VL_W'(NUM_LANE - 1)) >> LANE_SH;
  assign beats_m1  = beats - 1'b1;
  assign accept    = i_ins_vld & o_ins_rdy;
  assign beat_last = (cnt_q == last_q);

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first. If a path left one
    // unassigned, synthesis would infer a latch.
    state_d   = state_q;
    o_ins_rdy = 1'b0;
    o_ls_vld  = 1'b0;
    done_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_ins_rdy = 1'b1;
        if (accept) begin
          if (beats != '0) state_d  = S_ISSUE;
          else             done_set = 1'b1;  // zero-length: retire immediately
        end
      end
      S_ISSUE: begin
        o_ls_vld = ~i_stall;
        if (!i_stall && beat_last) begin
          if (ISSUE_GAP == 0) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (gap_q == 4'd0) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples the values from before the clock edge, whatever the statement order.
    if (!rst_n) begin
      cnt_q    <= '0;
      last_q   <= '0;
      gap_q    <= '0;
      op_q     <= '0;
      scalar_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      if (accept) begin
        cnt_q    <= '0;
        last_q   <= beats_m1[CNT_W-1:0];
        op_q     <= i_ins_op;
        scalar_q <= i_ins_scalar;
      end else if (state_q == S_ISSUE && !i_stall && !beat_last) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_ISSUE && state_d == S_DRAIN) gap_q <= GAP_LOAD;
      else if (state_q == S_DRAIN && gap_q != 4'd0) gap_q <= gap_q - 1'b1;
    end
  end

  assign o_seq_vmu_cnt       = cnt_q;
  assign o_seq_vmu_op_ls     = op_q;
  assign o_seq_vmu_scalar_ls = scalar_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_done              = done_q;

`ifdef VMU_LS_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_beats <= '0;
      o_perf_stall <= '0;
    end else begin
      if (o_ls_vld && o_perf_beats != 32'hFFFF_FFFF)
        o_perf_beats <= o_perf_beats + 32'd1;
      if (state_q == S_ISSUE && i_stall && o_perf_stall != 32'hFFFF_FFFF)
        o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vmu_ls_seq.sv
// -----------------------------------------------------------------------------
// tb_vmu_ls_seq -- directed self-checking bench for vmu_ls_seq at its default
// parameters (VLMAX=256, NUM_LANE=32, ISSUE_GAP=4). Inputs change 1ns after a
// rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vmu_ls_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ins_vld;
  logic        o_ins_rdy;
  logic [1:0]  i_ins_op;
  logic [31:0] i_ins_scalar;
  logic [8:0]  i_ins_vl;
  logic        i_stall;
  logic        o_ls_vld;
  logic [2:0]  o_seq_vmu_cnt;
  logic [1:0]  o_seq_vmu_op_ls;
  logic [31:0] o_seq_vmu_scalar_ls;
  logic        o_busy;
  logic        o_done;
`ifdef VMU_LS_SEQ_PERF_EN
  logic [31:0] o_perf_beats;
  logic [31:0] o_perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vmu_ls_seq dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_ins_vld           (i_ins_vld),
    .o_ins_rdy           (o_ins_rdy),
    .i_ins_op            (i_ins_op),
    .i_ins_scalar        (i_ins_scalar),
    .i_ins_vl            (i_ins_vl),
    .i_stall             (i_stall),
    .o_ls_vld            (o_ls_vld),
    .o_seq_vmu_cnt       (o_seq_vmu_cnt),
    .o_seq_vmu_op_ls     (o_seq_vmu_op_ls),
    .o_seq_vmu_scalar_ls (o_seq_vmu_scalar_ls),
    .o_busy              (o_busy),
    .o_done              (o_done)
`ifdef VMU_LS_SEQ_PERF_EN
    ,
    .o_perf_beats        (o_perf_beats),
    .o_perf_stall        (o_perf_stall)
`endif
  );

  // Pulse reset between two falling edges, then leave the bench at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_ins_vld = 1'b0; i_ins_op = '0; i_ins_scalar = '0;
    i_ins_vl = '0; i_stall = 1'b0;
    #12;
    checks++; if (o_ins_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", o_ins_rdy); end
    checks++; if (o_ls_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_ls_vld); end
    checks++; if (o_seq_vmu_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_seq_vmu_cnt); end
    checks++; if (o_seq_vmu_op_ls !== 2'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", o_seq_vmu_op_ls); end
    checks++; if (o_seq_vmu_scalar_ls !== 32'd0) begin errors++; $display("FAIL reset_scalar got=%0d exp=0", o_seq_vmu_scalar_ls); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one instruction at the edge that ends the current cycle T, then
  // checks cycles T+1..T+ncyc. stall_mask[k] holds i_stall high in cycle T+k.
  // The expected beat stream comes from a beat counter kept in this task. The
  // retire cycle done_at is worked out by hand for each call.
  task automatic run_ins(input string name, input logic [1:0] op,
                         input logic [31:0] sc, input logic [8:0] vl,
                         input int nbeats, input logic [15:0] stall_mask,
                         input int done_at, input int ncyc);
    int   issued;
    logic exp_vld;
    issued = 0;
    checks++; if (o_ins_rdy !== 1'b1) begin errors++; $display("FAIL %s pre_rdy got=%b exp=1", name, o_ins_rdy); end
    i_ins_vld = 1'b1; i_ins_op = op; i_ins_scalar = sc; i_ins_vl = vl;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      i_ins_vld = 1'b0;
      i_stall   = stall_mask[k];
      @(negedge clk);
      exp_vld = (issued < nbeats) && !stall_mask[k];
      checks++; if (o_ls_vld !== exp_vld) begin errors++; $display("FAIL %s vld c%0d got=%b exp=%b", name, k, o_ls_vld, exp_vld); end
      if (exp_vld) begin
        checks++;
        if (o_seq_vmu_cnt !== 3'(issued) || o_seq_vmu_op_ls !== op || o_seq_vmu_scalar_ls !== sc) begin
          errors++;
          $display("FAIL %s beat c%0d got cnt=%0d op=%0d sc=%0d exp cnt=%0d op=%0d sc=%0d",
                   name, k, o_seq_vmu_cnt, o_seq_vmu_op_ls, o_seq_vmu_scalar_ls, issued, op, sc);
        end
        issued++;
      end
      checks++; if (o_done !== (k == done_at)) begin errors++; $display("FAIL %s done c%0d got=%b exp=%b", name, k, o_done, (k == done_at)); end
      checks++; if (o_ins_rdy !== (k >= done_at)) begin errors++; $display("FAIL %s rdy c%0d got=%b exp=%b", name, k, o_ins_rdy, (k >= done_at)); end
      checks++; if (o_busy !== (k < done_at)) begin errors++; $display("FAIL %s busy c%0d got=%b exp=%b", name, k, o_busy, (k < done_at)); end
    end
    i_stall = 1'b0;
  endtask

  // 100 elements make 4 beats. DRAIN lasts 4 cycles. Done at T+9.
  task automatic test_basic();
    run_ins("basic", 2'd2, 32'd123, 9'd100, 4, 16'h0000, 9, 10);
  endtask

  // 300 clamps to 256, which is 8 beats. Done at T+13.
  task automatic test_clamp();
    run_ins("clamp", 2'd1, 32'hDEAD_0000, 9'd300, 8, 16'h0000, 13, 14);
  endtask

  // 64 elements make 2 beats. A stall in T+1 and T+2 pushes the beats to T+3/T+4. Done at T+9.
  task automatic test_stall();
    do_reset();
    run_ins("stall", 2'd3, 32'h55, 9'd64, 2, 16'b0000_0000_0000_0110, 9, 10);
`ifdef VMU_LS_SEQ_PERF_EN
    checks++; if (o_perf_stall !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", o_perf_stall); end
    checks++; if (o_perf_beats !== 32'd2) begin errors++; $display("FAIL perf_beats got=%0d exp=2", o_perf_beats); end
`endif
  endtask

  // vl=0 retires at T+1. A vl=32 instruction offered then is taken at edge T+1.
  task automatic test_zero_vl();
    checks++; if (o_ins_rdy !== 1'b1) begin errors++; $display("FAIL zero pre_rdy got=%b exp=1", o_ins_rdy); end
    i_ins_vld = 1'b1; i_ins_op = 2'd1; i_ins_scalar = 32'd7; i_ins_vl = 9'd0;
    @(posedge clk); #1;
    i_ins_op = 2'd2; i_ins_scalar = 32'd99; i_ins_vl = 9'd32;
    @(negedge clk);
    checks++; if (o_ls_vld !== 1'b0) begin errors++; $display("FAIL zero vld_t1 got=%b exp=0", o_ls_vld); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero done_t1 got=%b exp=1", o_done); end
    checks++; if (o_ins_rdy !== 1'b1) begin errors++; $display("FAIL zero rdy_t1 got=%b exp=1", o_ins_rdy); end
    @(posedge clk); #1;
    i_ins_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ls_vld !== 1'b1 || o_seq_vmu_cnt !== 3'd0 || o_seq_vmu_scalar_ls !== 32'd99) begin
      errors++;
      $display("FAIL zero second_beat got vld=%b cnt=%0d sc=%0d exp vld=1 cnt=0 sc=99",
               o_ls_vld, o_seq_vmu_cnt, o_seq_vmu_scalar_ls);
    end
    checks++; if (o_ins_rdy !== 1'b0) begin errors++; $display("FAIL zero rdy_t2 got=%b exp=0", o_ins_rdy); end
    // Beat at T+2, DRAIN T+3..T+6, done at T+7.
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      checks++; if (o_done !== (k == 7)) begin errors++; $display("FAIL zero done c%0d got=%b exp=%b", k, o_done, (k == 7)); end
    end
  endtask

  // i_ins_vld stays high for two vl=32 instructions. The first retires at T+6,
  // the second is taken at edge T+6, beats at T+7 and retires at T+12.
  task automatic test_back_to_back();
    logic exp_vld;
    i_ins_vld = 1'b1; i_ins_op = 2'd0; i_ins_scalar = 32'd1000; i_ins_vl = 9'd32;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 7) i_ins_vld = 1'b0;
      @(negedge clk);
      exp_vld = (k == 1) || (k == 7);
      checks++; if (o_ls_vld !== exp_vld) begin errors++; $display("FAIL b2b vld c%0d got=%b exp=%b", k, o_ls_vld, exp_vld); end
      checks++; if (o_ins_rdy !== (k == 6 || k == 12)) begin errors++; $display("FAIL b2b rdy c%0d got=%b exp=%b", k, o_ins_rdy, (k == 6 || k == 12)); end
      checks++; if (o_done !== (k == 6 || k == 12)) begin errors++; $display("FAIL b2b done c%0d got=%b exp=%b", k, o_done, (k == 6 || k == 12)); end
    end
  endtask

  // Reset is asserted in cycle T+2 of a 4-beat (vl=128) instruction.
  task automatic test_mid_reset();
    i_ins_vld = 1'b1; i_ins_op = 2'd2; i_ins_scalar = 32'd4242; i_ins_vl = 9'd128;
    @(posedge clk); #1;
    i_ins_vld = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_ls_vld !== 1'b1 || o_seq_vmu_cnt !== 3'd1) begin errors++; $display("FAIL mrst pre got vld=%b cnt=%0d exp vld=1 cnt=1", o_ls_vld, o_seq_vmu_cnt); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (o_ls_vld !== 1'b0) begin errors++; $display("FAIL mrst vld got=%b exp=0", o_ls_vld); end
    checks++; if (o_seq_vmu_cnt !== 3'd0) begin errors++; $display("FAIL mrst cnt got=%0d exp=0", o_seq_vmu_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mrst busy got=%b exp=0", o_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mrst done c%0d got=%b exp=0", k, o_done); end
      checks++; if (o_ins_rdy !== 1'b1) begin errors++; $display("FAIL mrst rdy c%0d got=%b exp=1", k, o_ins_rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stall();
    test_zero_vl();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmu_ls_seq.md
# vmu_ls_seq

Sequencer-side issue stage for vector load/store instructions. Accepts one vector memory instruction per valid/ready handshake and expands it into a stream of lane-group beats (`o_ls_vld` plus beat count, op and scalar base) that drive the LSU address-generation stage directly downstream. It enforces a post-instruction drain gap so that the fixed-latency LSU/SPM pipeline empties before the next instruction issues.

## Interface
Parameters:
- `LSU_OP_WIDTH`, 2: load/store opcode width, passed through unmodified.
- `SCALAR_WIDTH`, 32: scalar base/stride operand width.
- `VLMAX`, 256: maximum vector length in elements; power of two.
- `NUM_LANE`, 32: elements per beat; power of two, divides `VLMAX`.
- `ISSUE_GAP`, 4: idle cycles inserted after the last beat; range 0..15.
- `CNT_W`, `$clog2(VLMAX/NUM_LANE)`: beat counter width (3 at defaults).

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `i_ins_vld`, in, 1: instruction valid.
- `o_ins_rdy`, out, 1: instruction ready.
- `i_ins_op`, in, `LSU_OP_WIDTH`: load/store opcode.
- `i_ins_scalar`, in, `SCALAR_WIDTH`: base address operand.
- `i_ins_vl`, in, `$clog2(VLMAX)+1`: vector length in elements.
- `i_stall`, in, 1: downstream hold; suppresses beat issue.
- `o_ls_vld`, out, 1: beat valid to LSU.
- `o_seq_vmu_cnt`, out, `CNT_W`: beat index within the instruction.
- `o_seq_vmu_op_ls`, out, `LSU_OP_WIDTH`: latched opcode.
- `o_seq_vmu_scalar_ls`, out, `SCALAR_WIDTH`: latched scalar.
- `o_busy`, out, 1: FSM not in IDLE.
- `o_done`, out, 1: one-cycle pulse when an instruction retires.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: `o_ins_rdy`=1. On accept (`i_ins_vld & o_ins_rdy` at a rising edge):
  - latch op and scalar;
  - compute `beats = ceil(min(vl, VLMAX) / NUM_LANE)`;
  - clear cnt;
  - if beats>0, go to ISSUE; if beats==0, stay in IDLE and pulse `o_done` next cycle.
- ISSUE: `o_ls_vld = ~i_stall` (combinational). On a cycle with `i_stall`=0:
  - if cnt==beats-1: go to DRAIN (or straight to IDLE if `ISSUE_GAP`=0);
  - otherwise cnt increments.
  - With `i_stall`=1, cnt, op and scalar hold.
- DRAIN: the gap counter loads `ISSUE_GAP-1` on entry and decrements each cycle. At 0, go to IDLE. `i_stall` is ignored.
- `o_done` is registered and asserted in the first IDLE cycle after ISSUE/DRAIN, coincident with `o_ins_rdy` rising.
- `i_ins_vl` > `VLMAX` clamps to `VLMAX` (`VLMAX/NUM_LANE` beats). There is no error flag.
- `o_seq_vmu_op_ls` and `o_seq_vmu_scalar_ls` hold their last latched value in IDLE and DRAIN.
- Back-to-back: `o_ins_rdy` is low throughout ISSUE and DRAIN. The next instruction is accepted no earlier than the `o_done` cycle.

## Timing
- Reset values: `o_ins_rdy`=1, `o_ls_vld`=0, `o_seq_vmu_cnt`=0, `o_seq_vmu_op_ls`=0, `o_seq_vmu_scalar_ls`=0, `o_busy`=0, `o_done`=0. State is IDLE.
- Accept at edge T: first beat (cnt=0) valid in cycle T+1.
- Without stalls, N beats occupy cycles T+1..T+N. DRAIN occupies T+N+1..T+N+`ISSUE_GAP`. `o_done` and `o_ins_rdy` are high in cycle T+N+`ISSUE_GAP`+1.
- Each stalled ISSUE cycle delays every later event by one cycle.
- vl=0: `o_done` in cycle T+1. `o_ins_rdy` stays 1, so a new accept is possible at edge T+1.
- Reset asserted mid-instruction: outputs go to reset values immediately (asynchronous). The in-flight instruction is dropped with no `o_done`.

## Configuration
- `VMU_LS_SEQ_PERF_EN` defined: adds outputs `o_perf_beats` [31:0] and `o_perf_stall` [31:0].
  - `o_perf_beats` counts issued beats (`o_ls_vld`=1).
  - `o_perf_stall` counts ISSUE cycles with `i_stall`=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

## Test plan
- vl=100, op=2, scalar=123, no stall, `ISSUE_GAP`=4, accept at T:
  - `o_ls_vld` high T+1..T+4 with cnt 0,1,2,3 and op=2, scalar=123;
  - `o_done` at T+9.
- vl=300: clamps to 8 beats, cnt 0..7, `o_done` at T+13.
- vl=0: no `o_ls_vld`; `o_done` at T+1; second instruction vl=32 accepted at T+1, single beat at T+2.
- vl=64 with `i_stall`=1 during T+1 and T+2:
  - `o_ls_vld` low T+1..T+2; beats at T+3 (cnt=0) and T+4 (cnt=1);
  - `o_done` at T+9;
  - with `VMU_LS_SEQ_PERF_EN`, `o_perf_stall`=2 and `o_perf_beats`=2.
- `i_ins_vld` held high across two vl=32 instructions: second accept exactly at the `o_done` cycle of the first. `o_ins_rdy`=0 in every intervening cycle.
- `rst_n` low during cycle T+2 of a vl=128 instruction: `o_ls_vld`, cnt, `o_busy` go to 0 immediately; no `o_done`; `o_ins_rdy`=1 after release.
